// File: rtl/multi_delaybuffer_if.sv
// Pixel stream bundle for multi_delaybuffer: input sample/valid/ready,
// output taps/valid/ready and primed flag. slave = buffer, master = env.
interface multi_delaybuffer_if #(
  parameter int width_p = 8,
  parameter int taps_p  = 3
);
  logic [width_p-1:0]        data_i;
  logic                      valid_i;
  logic                      ready_o;
  logic                      valid_o;
  logic [taps_p*width_p-1:0] data_o;
  logic                      ready_i;
  logic                      primed_o;

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, valid_o, data_o, primed_o
  );

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, valid_o, data_o, primed_o
  );
endinterface

// File: rtl/multi_delaybuffer.sv
// Multi-tap line delay buffer: tap k = sample accepted k*delay_p beats ago.
// Ports: clk_i, reset_i (async, high), bus (slave: data/valid/ready in,
// taps/valid/ready/primed out). Option: MULTI_DELAYBUFFER_ZERO_FILL_EN
// forces taps whose source precedes reset to zero.
module multi_delaybuffer #(
  parameter int width_p = 8,
  parameter int delay_p = 8,
  parameter int taps_p  = 3
) (
  input logic               clk_i,
  input logic               reset_i,
  multi_delaybuffer_if.slave bus
);
  localparam int ptr_w = (delay_p > 1) ? $clog2(delay_p) : 1;
  localparam int lf_w  = (taps_p > 1) ? $clog2(taps_p) : 1;
  localparam logic [ptr_w-1:0] ptr_last = ptr_w'(delay_p - 1);
  localparam logic [lf_w-1:0]  lf_max   = lf_w'(taps_p - 1);

  logic             accept;
  logic             wrap;
  logic [ptr_w-1:0] ptr_q;
  logic [ptr_w-1:0] ptr_d;
  logic [lf_w-1:0]  lf_q;
  logic [lf_w-1:0]  lf_d;
  logic             valid_q;
  logic             primed_q;
  logic             pend_q;
  logic [ptr_w-1:0] pend_addr_q;
  logic [width_p-1:0] tap0_q;
  wire  [taps_p*width_p-1:0] taps_flat;

  assign bus.ready_o = ~valid_q | bus.ready_i;
  assign accept      = bus.valid_i & bus.ready_o;
  assign wrap        = (ptr_q == ptr_last);

  always_comb begin
    ptr_d = wrap ? '0 : ptr_q + ptr_w'(1);
    lf_d  = lf_q;
    if (accept && wrap && lf_q != lf_max)
      lf_d = lf_q + lf_w'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q       <= '0;
      lf_q        <= '0;
      valid_q     <= 1'b0;
      primed_q    <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      tap0_q      <= '0;
    end else begin
      pend_q   <= accept;
      lf_q     <= lf_d;
      primed_q <= (lf_d == lf_max);
      if (accept) begin
        ptr_q       <= ptr_d;
        pend_addr_q <= ptr_q;
        tap0_q      <= bus.data_i;
        valid_q     <= 1'b1;
      end else if (bus.ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign taps_flat[0 +: width_p] = tap0_q;

  // Bank k is fed from tap k-1 one cycle after the accept, once that
  // tap's registered read is available; the write never waits on input.
  for (genvar k = 1; k < taps_p; k++) begin : g_bank
    logic [width_p-1:0] mem [delay_p];
    logic [width_p-1:0] prev;
    logic [width_p-1:0] rd;
    logic [width_p-1:0] tap_q;
    logic               fill;

    assign prev = taps_flat[(k-1)*width_p +: width_p];
    // Only with delay_p=1 can the pending write hit the address read now.
    assign rd = (pend_q && pend_addr_q == ptr_q) ? prev : mem[ptr_q];

`ifdef MULTI_DELAYBUFFER_ZERO_FILL_EN
    assign fill = (lf_q < lf_w'(k));
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
      if (pend_q)
        mem[pend_addr_q] <= prev;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
        tap_q <= '0;
      else if (accept)
        tap_q <= fill ? '0 : rd;
    end

    assign taps_flat[k*width_p +: width_p] = tap_q;
  end

  assign bus.valid_o  = valid_q;
  assign bus.data_o   = taps_flat;
  assign bus.primed_o = (taps_p == 1) ? 1'b1 : primed_q;
endmodule
